// File: rtl/mic_pkg.sv
// rtl/mic_pkg.sv - shared types and constants for the PDM microphone capture path
package mic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } mic_state_e;

  // Defaults shared with the audio buffer: 100 MHz system clock, 2 MHz mic clock
  localparam int MIC_CLK_DIV = 25;
  localparam int MIC_WIN_LEN = 128;

  function automatic int mic_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/mic_pdm_ctrl_if.sv
// rtl/mic_pdm_ctrl_if.sv - PCM sample handshake between capture sequencer and audio buffer
interface mic_pdm_ctrl_if
  import mic_pkg::*;
#(
  parameter int PCM_W = mic_clog2(MIC_WIN_LEN + 1)
);
  logic [PCM_W-1:0] pcm_data;
  logic             pcm_valid;
  logic             pcm_ready;

  modport master (output pcm_data, output pcm_valid, input pcm_ready);
  modport slave  (input pcm_data, input pcm_valid, output pcm_ready);
endinterface

// File: rtl/mic_clk_gen.sv
// rtl/mic_clk_gen.sv - enable-gated mic clock divider with sampling-edge tick
module mic_clk_gen
  import mic_pkg::*;
#(
  parameter int CLK_DIV = MIC_CLK_DIV,
  parameter int CHANNEL = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic mic_clk,
  output logic tick
);
  localparam int DIV_W = (CLK_DIV > 1) ? mic_clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Left channel samples on the falling edge, right channel on the rising edge
  localparam logic TICK_LEVEL = (CHANNEL == 0) ? 1'b1 : 1'b0;

  logic [DIV_W-1:0] div;
  logic             at_last;

  assign at_last = (div == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div     <= '0;
      mic_clk <= 1'b0;
    end else if (!en || clr) begin
      div     <= '0;
      mic_clk <= 1'b0;
    end else if (at_last) begin
      div     <= '0;
      mic_clk <= ~mic_clk;
    end else begin
      div <= div + 1'b1;
    end
  end

  // A stop cycle never produces a tick, so a stopping window cannot complete
  assign tick = en && !clr && at_last && (mic_clk == TICK_LEVEL);

endmodule

// File: rtl/mic_pdm_ctrl.sv
// rtl/mic_pdm_ctrl.sv - PDM mic sequencer: clocking, warm-up, ones-count windows to PCM samples
module mic_pdm_ctrl
  import mic_pkg::*;
#(
  parameter int CLK_DIV  = MIC_CLK_DIV,
  parameter int WIN_LEN  = MIC_WIN_LEN,
  parameter int WARM_WIN = 4,
  parameter int CHANNEL  = 0,
  parameter int PCM_W    = mic_clog2(WIN_LEN + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  output logic           mic_clk,
  output logic           mic_lr,
  input  logic           mic_data,
  mic_pdm_ctrl_if.master pcm,
  output logic           busy,
  output logic           overrun
);
  localparam int BIT_W = mic_clog2(WIN_LEN);
  localparam logic [BIT_W-1:0] WIN_LAST = BIT_W'(WIN_LEN - 1);
  localparam int WC_W = (WARM_WIN > 1) ? mic_clog2(WARM_WIN) : 1;
  localparam logic [WC_W-1:0] WARM_LAST = WC_W'((WARM_WIN > 0) ? WARM_WIN - 1 : 0);

  mic_state_e       state, state_nxt;
  logic             sync1, sync2;
  logic             tick, win_done, run_done, launch, clr_win;
  logic [BIT_W-1:0] bit_cnt;
  logic [PCM_W-1:0] acc, win_count;
  logic [WC_W-1:0]  warm_cnt;

  assign mic_lr = (CHANNEL != 0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= mic_data;
      sync2 <= sync1;
    end
  end

  mic_clk_gen #(.CLK_DIV(CLK_DIV), .CHANNEL(CHANNEL)) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .en      (busy),
    .clr     (stop),
    .mic_clk (mic_clk),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start && !stop) state_nxt = (WARM_WIN == 0) ? ST_RUN : ST_WARMUP;
      ST_WARMUP: if (stop) state_nxt = ST_IDLE;
                 else if (win_done && warm_cnt == WARM_LAST) state_nxt = ST_RUN;
      ST_RUN:    if (stop) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == ST_WARMUP) || (state == ST_RUN);
    launch   = (state == ST_IDLE) && start && !stop;
    clr_win  = !busy || stop;
    run_done = win_done && (state == ST_RUN);
  end

  // The bit sampled on the last tick belongs to the window that is closing
  assign win_done  = tick && (bit_cnt == WIN_LAST);
  assign win_count = acc + PCM_W'(sync2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt  <= '0;
      acc      <= '0;
      warm_cnt <= '0;
    end else if (clr_win) begin
      bit_cnt  <= '0;
      acc      <= '0;
      warm_cnt <= '0;
    end else if (tick) begin
      if (win_done) begin
        bit_cnt <= '0;
        acc     <= '0;
        if (state == ST_WARMUP) warm_cnt <= warm_cnt + 1'b1;
      end else begin
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= win_count;
      end
    end
  end

  // An unconsumed sample is never overwritten; the newer one is dropped instead
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcm.pcm_data  <= '0;
      pcm.pcm_valid <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (launch) overrun <= 1'b0;
      if (run_done) begin
        if (pcm.pcm_valid && !pcm.pcm_ready) begin
          overrun <= 1'b1;
        end else begin
          pcm.pcm_data  <= win_count;
          pcm.pcm_valid <= 1'b1;
        end
      end else if (pcm.pcm_valid && pcm.pcm_ready) begin
        pcm.pcm_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mic_pdm_ctrl.sv
// tb/tb_mic_pdm_ctrl.sv - randomized bench for mic_pdm_ctrl, both channels against a window-level model
module tb_mic_pdm_ctrl;
  localparam int CLK_DIV  = 2;
  localparam int WIN_LEN  = 8;
  localparam int WARM_WIN = 1;
  localparam int PCM_W    = 4;
  localparam int TPER     = 2 * CLK_DIV;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic mic_data = 1'b0;
  logic pcm_ready = 1'b0;
  wire [1:0] d_mic_clk, d_mic_lr, d_busy, d_ovr;

  int data_mode = 0;
  bit data_level = 1'b0;
  int tog_cnt = 0;

  int n_tests = 0;
  int n_fail = 0;

  mic_pdm_ctrl_if #(.PCM_W(PCM_W)) pif0 ();
  mic_pdm_ctrl_if #(.PCM_W(PCM_W)) pif1 ();
  assign pif0.pcm_ready = pcm_ready;
  assign pif1.pcm_ready = pcm_ready;

  mic_pdm_ctrl #(.CLK_DIV(CLK_DIV), .WIN_LEN(WIN_LEN), .WARM_WIN(WARM_WIN), .CHANNEL(0), .PCM_W(PCM_W)) dut0 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mic_clk(d_mic_clk[0]), .mic_lr(d_mic_lr[0]),
    .mic_data(mic_data), .pcm(pif0), .busy(d_busy[0]), .overrun(d_ovr[0]));

  mic_pdm_ctrl #(.CLK_DIV(CLK_DIV), .WIN_LEN(WIN_LEN), .WARM_WIN(WARM_WIN), .CHANNEL(1), .PCM_W(PCM_W)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mic_clk(d_mic_clk[1]), .mic_lr(d_mic_lr[1]),
    .mic_data(mic_data), .pcm(pif1), .busy(d_busy[1]), .overrun(d_ovr[1]));

  always #5 clk = ~clk;

  // mic_data source: 0 constant level, 1 toggle once per tick period, 2 random per clk
  always @(posedge clk) begin
    #1;
    case (data_mode)
      0: mic_data = data_level;
      1: begin
        tog_cnt++;
        if (tog_cnt % TPER == 0) mic_data = ~mic_data;
      end
      default: mic_data = 1'($urandom);
    endcase
  end

  function automatic int get_valid(input int ch);
    return (ch == 0) ? int'(pif0.pcm_valid) : int'(pif1.pcm_valid);
  endfunction

  function automatic int get_data(input int ch);
    return (ch == 0) ? int'(pif0.pcm_data) : int'(pif1.pcm_data);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tick k of a capture lands at a fixed offset within each mic clock period
  bit m_busy[2];
  int m_i[2], m_acc[2], m_bits[2], m_wins[2], m_data[2];
  bit m_valid[2], m_ovr[2];
  bit h1, h2;

  always @(negedge clk) begin
    if (!reset) begin
      for (int ch = 0; ch < 2; ch++) begin
        m_busy[ch] = 0; m_i[ch] = 0; m_acc[ch] = 0; m_bits[ch] = 0; m_wins[ch] = 0;
        m_valid[ch] = 0; m_data[ch] = 0; m_ovr[ch] = 0;
      end
      h1 = 0;
      h2 = 0;
    end else begin
      for (int ch = 0; ch < 2; ch++) begin : per_ch
        bit done;
        int cnt, phase;
        chk("busy", int'(d_busy[ch]), int'(m_busy[ch]));
        chk("mic_clk", int'(d_mic_clk[ch]), m_busy[ch] ? (m_i[ch] / CLK_DIV) % 2 : 0);
        chk("mic_lr", int'(d_mic_lr[ch]), ch);
        chk("pcm_valid", get_valid(ch), int'(m_valid[ch]));
        if (m_valid[ch]) chk("pcm_data", get_data(ch), m_data[ch]);
        chk("overrun", int'(d_ovr[ch]), int'(m_ovr[ch]));
        phase = (ch == 0) ? TPER - 1 : CLK_DIV - 1;
        done = 0;
        cnt = 0;
        if (m_busy[ch] && !stop && (m_i[ch] % TPER == phase)) begin
          m_acc[ch] += int'(h2);
          m_bits[ch]++;
          if (m_bits[ch] == WIN_LEN) begin
            done = (m_wins[ch] >= WARM_WIN);
            m_wins[ch]++;
            cnt = m_acc[ch];
            m_acc[ch] = 0;
            m_bits[ch] = 0;
          end
        end
        if (done) begin
          if (m_valid[ch] && !pcm_ready) m_ovr[ch] = 1;
          else begin m_data[ch] = cnt; m_valid[ch] = 1; end
        end else if (m_valid[ch] && pcm_ready) begin
          m_valid[ch] = 0;
        end
        if (m_busy[ch] && stop) m_busy[ch] = 0;
        else if (!m_busy[ch] && start && !stop) begin
          m_busy[ch] = 1; m_i[ch] = 0; m_acc[ch] = 0; m_bits[ch] = 0; m_wins[ch] = 0; m_ovr[ch] = 0;
        end else if (m_busy[ch]) m_i[ch]++;
      end
      h2 = h1;
      h1 = mic_data;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  // Returns cycles waited until pcm_valid; consumes the cycle holding the sample
  task automatic wait_sample(input int ch, output int data, output int n);
    n = 0;
    while (get_valid(ch) == 0 && n < 200) begin
      cyc(1);
      n++;
    end
    chk("sample_seen", get_valid(ch), 1);
    data = get_data(ch);
    cyc(1);
  endtask

  int d, n;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(d_busy[0]), 0);
    chk("rst_mic_clk", int'(d_mic_clk[0]), 0);
    chk("rst_valid", get_valid(0), 0);
    chk("rst_data", get_data(0), 0);
    chk("rst_overrun", int'(d_ovr[0]), 0);
    chk("rst_mic_lr1", int'(d_mic_lr[1]), 1);
    reset = 1'b1;
    cyc(2);

    start = 1'b1; stop = 1'b1;
    cyc(1);
    start = 1'b0; stop = 1'b0;
    cyc(2);
    chk("start_stop_idle", int'(d_busy[0]), 0);

    data_level = 1'b1; pcm_ready = 1'b1;
    cyc(4);
    pulse_start();
    wait_sample(0, d, n);
    chk("first_latency_in_range", int'((n + 1) >= 63 && (n + 1) <= 65), 1);
    chk("ones_count", d, 8);
    chk("mic_lr0", int'(d_mic_lr[0]), 0);
    chk("valid_one_cycle", get_valid(0), 0);
    wait_sample(0, d, n);
    chk("sample_period", n + 1, 32);
    chk("ones_count2", d, 8);

    data_level = 1'b0;
    cyc(70);
    wait_sample(0, d, n);
    chk("zeros_count_ch0", d, 0);
    wait_sample(1, d, n);
    chk("zeros_count_ch1", d, 0);
    data_mode = 1;
    cyc(40);
    wait_sample(0, d, n);
    wait_sample(0, d, n);
    chk("toggle_count_ch0", d, 4);
    wait_sample(1, d, n);
    wait_sample(1, d, n);
    chk("toggle_count_ch1", d, 4);

    data_mode = 2;
    wait_sample(0, d, n);
    pcm_ready = 1'b0;
    cyc(99);
    chk("held_valid", get_valid(0), 1);
    chk("overrun_set", int'(d_ovr[0]), 1);
    pcm_ready = 1'b1;
    cyc(1);
    chk("drained", get_valid(0), 0);
    chk("overrun_sticky", int'(d_ovr[0]), 1);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    cyc(2);
    pulse_start();
    chk("overrun_cleared", int'(d_ovr[0]), 0);

    cyc(53);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    chk("stop_busy0", int'(d_busy[0]), 0);
    chk("stop_mic_clk0", int'(d_mic_clk[0]), 0);
    chk("stop_busy1", int'(d_busy[1]), 0);
    cyc(60);
    chk("no_sample_after_stop", get_valid(0), 0);
    pulse_start();
    wait_sample(0, d, n);
    chk("rewarm_latency_in_range", int'((n + 1) >= 63 && (n + 1) <= 65), 1);

    cyc(40);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("async_busy", int'(d_busy[0]), 0);
    chk("async_mic_clk", int'(d_mic_clk[0]), 0);
    chk("async_data", get_data(0), 0);
    chk("async_overrun", int'(d_ovr[0]), 0);
    chk("async_busy1", int'(d_busy[1]), 0);
    cyc(3);
    reset = 1'b1;
    cyc(20);
    chk("idle_after_reset", int'(d_busy[0]), 0);

    pulse_start();
    wait_sample(0, d, n);
    cyc(10);
    pulse_start();
    wait_sample(0, d, n);
    chk("cadence_after_restart", 12 + n, 32);

    for (int k = 0; k < 3000; k++) begin
      pcm_ready = ($urandom_range(0, 3) != 0);
      stop = ($urandom_range(0, 299) == 0);
      start = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    start = 1'b0;
    stop = 1'b0;
    cyc(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
